// File: rtl/adder_serial_nbit_pkg.sv
// ---------------------------------------------------------------------------
// adder_serial_nbit_pkg
//   Shared definitions for the chunk-serial adder/subtractor:
//   - state_e        : FSM state encoding (IDLE / RUN / DONE)
//   - idx_width()    : width of the chunk index counter (clog2, minimum 1)
//   - full_add_1bit(): single-bit full adder, returns {carry_out, sum}
//   - ovf_from_carries(): two's-complement overflow from the MSB carries
// ---------------------------------------------------------------------------
package adder_serial_nbit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int idx_width(input int n_chunks);
    return (n_chunks > 1) ? $clog2(n_chunks) : 1;
  endfunction

  // Returns {carry_out, sum}.
  function automatic logic [1:0] full_add_1bit(input logic a, input logic b, input logic ci);
    logic s;
    logic co;
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
    return {co, s};
  endfunction

  // Signed overflow: carry into the sign bit differs from carry out of it.
  function automatic logic ovf_from_carries(input logic c_into_msb, input logic c_out_msb);
    return c_into_msb ^ c_out_msb;
  endfunction

endpackage

// File: rtl/adder_full_nbit.sv
// ---------------------------------------------------------------------------
// adder_full_nbit
//   Combinational CHUNK-bit ripple-carry adder built from 1-bit full adders.
//   Ports:
//     a, b   in  CHUNK  operand chunks
//     ci     in  1      carry in
//     s      out CHUNK  sum chunk
//     co     out 1      carry out of the chunk MSB
//     c_msb  out 1      carry into the chunk MSB (for signed overflow)
// ---------------------------------------------------------------------------
module adder_full_nbit
  import adder_serial_nbit_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0]   carry_s;
  logic [CHUNK-1:0] sum_s;

  // Ripple chain evaluated in one process so the carry vector has no
  // combinational feedback between separate drivers.
  always_comb begin
    carry_s    = '0;
    sum_s      = '0;
    carry_s[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      {carry_s[i+1], sum_s[i]} = full_add_1bit(a[i], b[i], carry_s[i]);
    end
  end

  assign s     = sum_s;
  assign co    = carry_s[CHUNK];
  assign c_msb = carry_s[CHUNK-1];

endmodule

// File: rtl/adder_serial_nbit.sv
// ---------------------------------------------------------------------------
// adder_serial_nbit
//   Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per clock,
//   LSB chunk first, with a registered carry between chunks.
//   Subtraction is done as add + ~aug + ~preC; the borrow-out is the inverted
//   final carry.
//   Ports:
//     Clk       in  1      clock (rising edge)
//     Reset_n   in  1      asynchronous active-low reset
//     start     in  1      request, sampled in IDLE or DONE only
//     sub       in  1      0: add+aug+preC, 1: add-aug-preC
//     add       in  WIDTH  addend / minuend
//     aug       in  WIDTH  augend / subtrahend
//     preC      in  1      carry-in / borrow-in
//     busy      out 1      high exactly while in RUN
//     done      out 1      one-cycle pulse, result valid
//     sum       out WIDTH  result, held until the next accepted start
//     proC      out 1      carry-out / borrow-out
//     overflow  out 1      two's-complement overflow of the result
// ---------------------------------------------------------------------------
module adder_serial_nbit
  import adder_serial_nbit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] add,
  input  logic [WIDTH-1:0] aug,
  input  logic             preC,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             proC,
  output logic             overflow
);

  localparam int N_CHUNKS = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int IDX_W    = idx_width(N_CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("adder_serial_nbit: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             proc_q, proc_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  int               base_s;
  logic [CHUNK-1:0] a_chunk_s;
  logic [CHUNK-1:0] b_chunk_s;
  logic [CHUNK-1:0] chunk_sum_s;
  logic             chunk_co_s;
  logic             chunk_cmsb_s;

  // Select the operand chunk addressed by the current index.
  always_comb begin
    base_s    = int'(idx_q) * CHUNK;
    a_chunk_s = a_q[base_s +: CHUNK];
    b_chunk_s = b_q[base_s +: CHUNK];
  end

  adder_full_nbit #(
    .CHUNK (CHUNK)
  ) u_chunk_add (
    .a     (a_chunk_s),
    .b     (b_chunk_s),
    .ci    (carry_q),
    .s     (chunk_sum_s),
    .co    (chunk_co_s),
    .c_msb (chunk_cmsb_s)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    sum_d   = sum_q;
    proc_d  = proc_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // Subtrahend and borrow-in are stored inverted so RUN only adds.
          state_d = ST_RUN;
          idx_d   = '0;
          a_d     = add;
          b_d     = sub ? ~aug : aug;
          sub_d   = sub;
          carry_d = sub ? ~preC : preC;
          sum_d   = '0;
          proc_d  = 1'b0;
          ovf_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d[base_s +: CHUNK] = chunk_sum_s;
        carry_d                = chunk_co_s;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          idx_d   = '0;
          proc_d  = sub_q ? ~chunk_co_s : chunk_co_s;
          ovf_d   = ovf_from_carries(chunk_cmsb_s, chunk_co_s);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      sum_q   <= '0;
      proc_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      sum_q   <= sum_d;
      proc_q  <= proc_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign proC     = proc_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_adder_serial_nbit.sv
// ---------------------------------------------------------------------------
// tb_adder_serial_nbit
//   Scoreboard bench: one 8-bit/2-bit-chunk instance for directed cases and
//   two 4-bit instances (1-bit and 4-bit chunks) driven together for an
//   exhaustive sweep. Expected results are pushed when a start is driven and
//   popped when the corresponding done pulse appears.
// ---------------------------------------------------------------------------
module tb_adder_serial_nbit;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: WIDTH=8, CHUNK=2
  logic       a_start, a_sub, a_preC;
  logic [7:0] a_add, a_aug;
  logic       a_busy, a_done, a_proC, a_ovf;
  logic [7:0] a_sum;

  adder_serial_nbit #(.WIDTH(8), .CHUNK(2)) u_dut_a (
    .Clk(clk), .Reset_n(rst_n), .start(a_start), .sub(a_sub), .add(a_add), .aug(a_aug),
    .preC(a_preC), .busy(a_busy), .done(a_done), .sum(a_sum), .proC(a_proC), .overflow(a_ovf)
  );

  // Instances B (CHUNK=1) and C (CHUNK=4) share WIDTH=4 stimulus
  logic       s_start, s_sub, s_preC;
  logic [3:0] s_add, s_aug;
  logic       b_busy, b_done, b_proC, b_ovf;
  logic [3:0] b_sum;
  logic       c_busy, c_done, c_proC, c_ovf;
  logic [3:0] c_sum;

  adder_serial_nbit #(.WIDTH(4), .CHUNK(1)) u_dut_b (
    .Clk(clk), .Reset_n(rst_n), .start(s_start), .sub(s_sub), .add(s_add), .aug(s_aug),
    .preC(s_preC), .busy(b_busy), .done(b_done), .sum(b_sum), .proC(b_proC), .overflow(b_ovf)
  );

  adder_serial_nbit #(.WIDTH(4), .CHUNK(4)) u_dut_c (
    .Clk(clk), .Reset_n(rst_n), .start(s_start), .sub(s_sub), .add(s_add), .aug(s_aug),
    .preC(s_preC), .busy(c_busy), .done(c_done), .sum(c_sum), .proC(c_proC), .overflow(c_ovf)
  );

  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [31:0] q_c[$];
  logic [31:0] exp_a, exp_b, exp_c;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {overflow, carry/borrow, result} from plain integer arithmetic.
  function automatic logic [31:0] model(input int w, input logic s, input logic [31:0] a,
                                        input logic [31:0] b, input logic c);
    logic [31:0] mask, full, res;
    logic cb, ov, sa, sb, sr;
    mask = (32'd1 << w) - 32'd1;
    if (s) full = (a & mask) - (b & mask) - {31'd0, c};
    else   full = (a & mask) + (b & mask) + {31'd0, c};
    res = full & mask;
    cb  = full[w];
    sa  = a[w-1];
    sb  = b[w-1];
    sr  = res[w-1];
    ov  = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return (32'(ov) << (w + 1)) | (32'(cb) << w) | res;
  endfunction

  // Scoreboard for instance A.
  always @(negedge clk) begin
    if (a_done) begin
      check_eq("a_busy_at_done", 32'(a_busy), 32'd0);
      check_eq("a_done_expected", 32'(q_a.size() != 0), 32'd1);
      if (q_a.size() != 0) begin
        exp_a = q_a.pop_front();
        check_eq("a_result", 32'({a_ovf, a_proC, a_sum}), exp_a);
      end
    end
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin
    if (b_done) begin
      check_eq("b_busy_at_done", 32'(b_busy), 32'd0);
      check_eq("b_done_expected", 32'(q_b.size() != 0), 32'd1);
      if (q_b.size() != 0) begin
        exp_b = q_b.pop_front();
        check_eq("b_result", 32'({b_ovf, b_proC, b_sum}), exp_b);
      end
    end
  end

  // Scoreboard for instance C.
  always @(negedge clk) begin
    if (c_done) begin
      check_eq("c_busy_at_done", 32'(c_busy), 32'd0);
      check_eq("c_done_expected", 32'(q_c.size() != 0), 32'd1);
      if (q_c.size() != 0) begin
        exp_c = q_c.pop_front();
        check_eq("c_result", 32'({c_ovf, c_proC, c_sum}), exp_c);
      end
    end
  end

  // One operation on A; operands are scrambled right after acceptance.
  task automatic run_a(input string tag, input logic s, input logic [7:0] x,
                       input logic [7:0] y, input logic c);
    int cyc;
    int busy_cnt;
    a_start = 1'b1; a_sub = s; a_add = x; a_aug = y; a_preC = c;
    q_a.push_back(model(8, s, {24'd0, x}, {24'd0, y}, c));
    @(posedge clk); #1;
    a_start = 1'b0; a_sub = ~s; a_add = ~x; a_aug = ~y; a_preC = ~c;
    cyc = 0;
    busy_cnt = 0;
    while (!a_done && cyc < 20) begin
      if (a_busy) busy_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    check_eq({tag, "_latency"}, 32'(cyc), 32'd4);
    check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
  endtask

  task automatic wait_done_a(input string tag);
    int cyc;
    cyc = 0;
    while (!a_done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq({tag, "_done_seen"}, 32'(a_done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cnt;
    int cyc;
    a_start = 1'b0; a_sub = 1'b0; a_preC = 1'b0; a_add = 8'h00; a_aug = 8'h00;
    s_start = 1'b0; s_sub = 1'b0; s_preC = 1'b0; s_add = 4'h0; s_aug = 4'h0;

    // Reset and idle
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_a", 32'({a_busy, a_done, a_proC, a_ovf, a_sum}), 32'd0);
    check_eq("reset_small", 32'({b_busy, b_done, b_proC, b_ovf, b_sum,
                                 c_busy, c_done, c_proC, c_ovf, c_sum}), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("idle_a", 32'({a_busy, a_done, a_proC, a_ovf, a_sum}), 32'd0);

    // Directed add / sub
    run_a("add_3c_45", 1'b0, 8'h3C, 8'h45, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("done_pulse_width", 32'(a_done), 32'd0);
    check_eq("sum_hold", 32'({a_ovf, a_proC, a_sum}), 32'h282);
    run_a("sub_10_20", 1'b1, 8'h10, 8'h20, 1'b0);
    run_a("sub_80_01", 1'b1, 8'h80, 8'h01, 1'b0);
    run_a("add_ff_01", 1'b0, 8'hFF, 8'h01, 1'b0);
    run_a("add_7f_01", 1'b0, 8'h7F, 8'h01, 1'b0);
    run_a("sub_00_00_b", 1'b1, 8'h00, 8'h00, 1'b1);
    run_a("sub_7f_ff", 1'b1, 8'h7F, 8'hFF, 1'b0);

    // Start held through RUN with changing operands, then back-to-back from DONE
    repeat (2) @(posedge clk);
    #1;
    a_start = 1'b1; a_sub = 1'b0; a_add = 8'h12; a_aug = 8'h34; a_preC = 1'b0;
    q_a.push_back(model(8, 1'b0, 32'h12, 32'h34, 1'b0));
    @(posedge clk); #1;
    busy_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (a_busy) busy_cnt++;
      a_add = 8'($urandom); a_aug = 8'($urandom);
      a_sub = 1'($urandom); a_preC = 1'($urandom);
      @(posedge clk); #1;
    end
    check_eq("hold_busy_cycles", 32'(busy_cnt), 32'd4);
    check_eq("hold_done", 32'(a_done), 32'd1);
    a_sub = 1'b1; a_add = 8'hA5; a_aug = 8'h5A; a_preC = 1'b1;
    q_a.push_back(model(8, 1'b1, 32'hA5, 32'h5A, 1'b1));
    @(posedge clk); #1;
    check_eq("b2b_busy_done", 32'({a_busy, a_done}), 32'h2);
    a_start = 1'b0; a_add = 8'h00; a_aug = 8'hFF;
    wait_done_a("b2b");

    // Reset in the middle of RUN
    repeat (2) @(posedge clk);
    #1;
    a_start = 1'b1; a_sub = 1'b0; a_add = 8'h55; a_aug = 8'h22; a_preC = 1'b0;
    @(posedge clk); #1;
    a_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("abort_running", 32'(a_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_outputs", 32'({a_busy, a_done, a_proC, a_ovf, a_sum}), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("abort_hold", 32'({a_busy, a_done, a_proC, a_ovf, a_sum}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_a("after_abort", 1'b0, 8'h5C, 8'h77, 1'b0);

    // Exhaustive WIDTH=4 sweep on both chunk sizes
    for (int si = 0; si < 2; si++) begin
      for (int ci = 0; ci < 2; ci++) begin
        for (int xi = 0; xi < 16; xi++) begin
          for (int yi = 0; yi < 16; yi++) begin
            s_start = 1'b1; s_sub = si[0]; s_preC = ci[0];
            s_add = 4'(xi); s_aug = 4'(yi);
            exp_b = model(4, si[0], 32'(xi), 32'(yi), ci[0]);
            q_b.push_back(exp_b);
            q_c.push_back(exp_b);
            @(posedge clk); #1;
            s_start = 1'b0;
            cyc = 0;
            while (!b_done && cyc < 12) begin
              @(posedge clk); #1;
              cyc++;
            end
            check_eq("small_done_seen", 32'(b_done), 32'd1);
          end
        end
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check_eq("a_queue_drained", 32'(q_a.size()), 32'd0);
    check_eq("b_queue_drained", 32'(q_b.size()), 32'd0);
    check_eq("c_queue_drained", 32'(q_c.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
